// File: rtl/sweep_packetizer_if.sv
// Sample handshake and FIFO write-port bundle for sweep_packetizer.
// The master modport is the packetizer side; slave is the feeder/FIFO side.
interface sweep_packetizer_if #(
    parameter int FREQ_BYTES = 4,
    parameter int MAG_BYTES  = 2
);
    logic                    sample_valid;
    logic                    sample_ready;
    logic [8*FREQ_BYTES-1:0] freq_word;
    logic [8*MAG_BYTES-1:0]  mag;
    logic [7:0]              fifo_data_in;
    logic                    fifo_wr_en;
    logic                    fifo_full;
    logic                    busy;
    logic [7:0]              seq_num;

    modport master (
        input  sample_valid, freq_word, mag, fifo_full,
        output sample_ready, fifo_data_in, fifo_wr_en, busy, seq_num
    );

    modport slave (
        output sample_valid, freq_word, mag, fifo_full,
        input  sample_ready, fifo_data_in, fifo_wr_en, busy, seq_num
    );
endinterface

// File: rtl/sweep_packetizer.sv
// Serialises one (freq_word, mag) sweep sample into a framed byte packet
// [sync, seq, freq MSB-first, mag MSB-first, xor checksum] for the UART TX FIFO.
module sweep_packetizer #(
    parameter int         FREQ_BYTES = 4,
    parameter int         MAG_BYTES  = 2,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                 clk_50m,
    input  logic                 reset,
    sweep_packetizer_if.master   bus
);
    localparam int PKT_LEN = 3 + FREQ_BYTES + MAG_BYTES;
    localparam int IDX_W   = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [7:0]              seq;
    logic [7:0]              csum;
    logic [8*FREQ_BYTES-1:0] freq_lat;
    logic [8*MAG_BYTES-1:0]  mag_lat;
    logic [7:0]              cur_byte;
    logic                    in_send;
    logic                    wr;

    assign in_send = (state == SEND);
    assign wr      = in_send && !bus.fifo_full;

    always_comb begin
        cur_byte = '0;
        if (idx == '0) begin
            cur_byte = SYNC_BYTE;
        end else if (idx == IDX_W'(1)) begin
            cur_byte = seq;
        end else if (idx == LAST_IDX) begin
            cur_byte = csum;
        end else begin
            for (int unsigned i = 0; i < FREQ_BYTES; i++) begin
                if (idx == IDX_W'(2 + i))
                    cur_byte = freq_lat[8*(FREQ_BYTES-1-i) +: 8];
            end
            for (int unsigned i = 0; i < MAG_BYTES; i++) begin
                if (idx == IDX_W'(2 + FREQ_BYTES + i))
                    cur_byte = mag_lat[8*(MAG_BYTES-1-i) +: 8];
            end
        end
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            seq      <= '0;
            csum     <= '0;
            freq_lat <= '0;
            mag_lat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        freq_lat <= bus.freq_word;
                        mag_lat  <= bus.mag;
                        idx      <= '0;
                        csum     <= '0;
                        state    <= SEND;
                    end
                end
                default: begin
                    if (wr) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            seq   <= seq + 8'd1;
                            state <= IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                            // Sync byte is excluded from the checksum.
                            if (idx != '0)
                                csum <= csum ^ cur_byte;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.sample_ready = !in_send;
    assign bus.busy         = in_send;
    assign bus.fifo_wr_en   = wr;
    assign bus.fifo_data_in = in_send ? cur_byte : '0;
    assign bus.seq_num      = seq;
endmodule

// File: tb/tb_sweep_packetizer.sv
// Self-checking bench for sweep_packetizer: directed sequence plus randomized
// samples and stalls, checked against a byte-list packet model.
module tb_sweep_packetizer;
    localparam int PKT_LEN = 9;
    typedef logic [7:0] bq_t[$];

    logic clk_50m = 1'b0;
    logic reset   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   hs_cnt  = 0;
    int   first_wr, last_wr, prev_last_wr;
    logic [7:0] seq_model = 8'h00;
    bq_t  got;

    sweep_packetizer_if #(.FREQ_BYTES(4), .MAG_BYTES(2)) bus ();

    sweep_packetizer #(.FREQ_BYTES(4), .MAG_BYTES(2), .SYNC_BYTE(8'hA5)) dut (
        .clk_50m (clk_50m),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_50m = ~clk_50m;

    always @(posedge clk_50m) begin
        cyc <= cyc + 1;
        if (!reset && bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1)
            hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t model(input logic [31:0] f, input logic [15:0] m, input logic [7:0] s);
        bq_t q;
        logic [7:0] x;
        x = 8'h00;
        q.push_back(8'hA5);
        q.push_back(s);
        for (int i = 3; i >= 0; i--) q.push_back(8'((f >> (8*i)) & 32'hFF));
        for (int i = 1; i >= 0; i--) q.push_back(8'((m >> (8*i)) & 32'hFF));
        for (int i = 1; i < q.size(); i++) x = x ^ q[i];
        q.push_back(x);
        return q;
    endfunction

    // Entered and left at posedge+1.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_wr_en", bus.fifo_wr_en, 0);
        chk("rst_data", bus.fifo_data_in, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_seq", bus.seq_num, 0);
        @(posedge clk_50m); #1;
        @(posedge clk_50m); #1;
        reset = 1'b0;
        #1;
        chk("rst_ready", bus.sample_ready, 1);
        seq_model = 8'h00;
    endtask

    // mode: 0 no stall, 1 five-cycle stall after third byte, 2 random stalls.
    task automatic run_packet(input logic [31:0] f, input logic [15:0] m, input int mode,
                              input bit hold, input int abort_at);
        bq_t exp;
        int  busy_cyc, stall, n, hs0;
        bit  full;
        busy_cyc = 0;
        stall    = 0;
        exp = model(f, m, seq_model);
        n = 0;
        while (bus.sample_ready !== 1'b1 && n < 50) begin
            @(posedge clk_50m); #1;
            n++;
        end
        chk("ready_wait", bus.sample_ready, 1);
        bus.freq_word    = f;
        bus.mag          = m;
        bus.sample_valid = 1'b1;
        hs0 = hs_cnt;
        @(posedge clk_50m); #1;
        if (!hold) bus.sample_valid = 1'b0;
        bus.freq_word = $urandom;
        bus.mag       = 16'($urandom);
        got.delete();
        for (int c = 0; c < 200 && got.size() < PKT_LEN; c++) begin
            if (abort_at >= 0 && got.size() == abort_at) begin
                bus.fifo_full = 1'b0;
                do_reset();
                return;
            end
            case (mode)
                1:       full = (got.size() == 3 && stall < 5);
                2:       full = ($urandom_range(0, 3) == 0);
                default: full = 1'b0;
            endcase
            if (full) stall++;
            bus.fifo_full = full;
            @(negedge clk_50m);
            busy_cyc++;
            chk("busy", bus.busy, 1);
            chk("ready_in_send", bus.sample_ready, 0);
            chk($sformatf("byte%0d", got.size()), bus.fifo_data_in, exp[got.size()]);
            chk("wr_en", bus.fifo_wr_en, !full);
            if (bus.fifo_wr_en === 1'b1) begin
                if (got.size() == 0) first_wr = cyc;
                last_wr = cyc;
                got.push_back(bus.fifo_data_in);
            end
            @(posedge clk_50m); #1;
        end
        bus.fifo_full = 1'b0;
        chk("pkt_len", got.size(), PKT_LEN);
        chk("done_busy", bus.busy, 0);
        chk("done_ready", bus.sample_ready, 1);
        chk("seq_num", bus.seq_num, 8'(seq_model + 8'd1));
        chk("one_handshake", hs_cnt, hs0 + 1);
        if (mode == 0) chk("busy_cycles", busy_cyc, PKT_LEN);
        if (mode == 1) chk("stall_cycles", busy_cyc, PKT_LEN + 5);
        seq_model = seq_model + 8'd1;
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.freq_word    = '0;
        bus.mag          = '0;
        bus.fifo_full    = 1'b0;
        #2;
        do_reset();

        // Basic packet: A5 00 12 34 56 78 BE EF 59
        run_packet(32'h12345678, 16'hBEEF, 0, 1'b0, -1);
        chk("basic_csum", got[8], 8'h59);
        chk("basic_seq1", bus.seq_num, 8'h01);

        // Backpressure after 0x12, from seq 0 again
        do_reset();
        run_packet(32'h12345678, 16'hBEEF, 1, 1'b0, -1);
        chk("bp_csum", got[8], 8'h59);
        chk("bp_byte3", got[3], 8'h34);

        // Randomized samples with random stalls
        for (int k = 0; k < 20; k++)
            run_packet($urandom, 16'($urandom), 2, 1'b0, -1);

        // Back-to-back with sample_valid held high
        prev_last_wr = -100;
        for (int k = 0; k < 4; k++) begin
            run_packet($urandom, 16'($urandom), 0, 1'b1, -1);
            if (k > 0) chk("b2b_gap", (first_wr - prev_last_wr) >= 2, 1);
            prev_last_wr = last_wr;
        end
        bus.sample_valid = 1'b0;

        // Reset while byte 4 is presented, then a clean packet from seq 0
        run_packet(32'hCAFEF00D, 16'h1234, 0, 1'b0, 4);
        run_packet(32'h0BADBEEF, 16'h5A5A, 0, 1'b0, -1);
        chk("post_rst_sync", got[0], 8'hA5);
        chk("post_rst_seq", got[1], 8'h00);

        // Sequence wrap: seq/checksum 00..FF then 00
        do_reset();
        for (int k = 0; k < 257; k++) begin
            run_packet(32'h0, 16'h0, 0, 1'b0, -1);
            chk("wrap_csum_eq_seq", got[8], got[1]);
        end
        chk("wrap_last_seq", got[1], 8'h00);
        chk("wrap_seq_num", bus.seq_num, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
